// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
// Fetches one sprite row from the sprite ROM into a local line buffer, then
// serves the buffered pixels to the pixel pipeline by column index.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start, i_row   one-cycle fetch request and the row to fetch
//   o_read           ROM read strobe (ROM acts on its rising edge)
//   o_address        ROM address, row*WIDTH+col, stable from REQ through WAIT
//   i_rgb_data       ROM data word, captured when i_valid is high in WAIT
//   i_valid          ROM data-valid pulse
//   i_px_index       line-buffer column to read
//   o_px_rgb         registered pixel at i_px_index (1-cycle latency)
//   o_busy           fetch in progress
//   o_line_valid     buffer holds a complete row
//   o_done           one-cycle pulse when a row completes
//   o_error          one-cycle pulse on an out-of-range row or a ROM timeout
module sprite_line_fetcher #(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 18,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [4:0]        i_row,
    output logic              o_read,
    output logic [ADDR_W-1:0] o_address,
    input  logic [DATA_W-1:0] i_rgb_data,
    input  logic              i_valid,
    input  logic [3:0]        i_px_index,
    output logic [DATA_W-1:0] o_px_rgb,
    output logic              o_busy,
    output logic              o_line_valid,
    output logic              o_done,
    output logic              o_error
);

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [4:0]          row_reg, row_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                line_valid_reg, line_valid_next;
    logic                error_reg, error_next;
    logic                buf_we;
    logic [DATA_W-1:0]   px_reg;

    logic [DATA_W-1:0]   line_buf [WIDTH];

    // State register; async reset so o_read (decoded from state) drops at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            cnt_reg        <= '0;
            line_valid_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            cnt_reg        <= cnt_next;
            line_valid_reg <= line_valid_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        cnt_next        = cnt_reg;
        line_valid_next = line_valid_reg;
        error_next      = 1'b0;
        buf_we          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    if (int'(i_row) >= HEIGHT) begin
                        error_next = 1'b1;
                    end else begin
                        row_next        = i_row;
                        col_next        = '0;
                        line_valid_next = 1'b0;
                        state_next      = REQ;
                    end
                end
            end
            REQ: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (i_valid) begin
                    buf_we = 1'b1;
                    if (col_reg == COL_W'(WIDTH - 1)) begin
                        state_next = DONE;
                    end else begin
                        col_next   = col_reg + 1'b1;
                        state_next = REQ;
                    end
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    // This idle cycle makes the count reach TIMEOUT: abort the row.
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                line_valid_next = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line buffer: contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            line_buf[col_reg] <= i_rgb_data;
        end
    end

    // Registered read port; columns beyond the row read as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            px_reg <= '0;
        end else if (int'(i_px_index) < WIDTH) begin
            px_reg <= line_buf[i_px_index[COL_W-1:0]];
        end else begin
            px_reg <= '0;
        end
    end

    // Address only changes when col/row change, i.e. on entry to REQ.
    assign o_address    = ADDR_W'(row_reg) * ADDR_W'(WIDTH) + ADDR_W'(col_reg);
    assign o_read       = (state_reg == REQ);
    assign o_busy       = (state_reg != IDLE);
    assign o_done       = (state_reg == DONE);
    assign o_line_valid = line_valid_reg;
    assign o_error      = error_reg;
    assign o_px_rgb     = px_reg;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
`timescale 1ns/1ps
module tb_sprite_line_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  row = '0;
    logic        read;
    logic [8:0]  address;
    logic [23:0] rgb_data = '0;
    logic        valid = 1'b0;
    logic [3:0]  px_index = '0;
    logic [23:0] px_rgb;
    logic        busy, line_valid, done, error;

    always #5 clk = ~clk;

    sprite_line_fetcher dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_row        (row),
        .o_read       (read),
        .o_address    (address),
        .i_rgb_data   (rgb_data),
        .i_valid      (valid),
        .i_px_index   (px_index),
        .o_px_rgb     (px_rgb),
        .o_busy       (busy),
        .o_line_valid (line_valid),
        .o_done       (done),
        .o_error      (error)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Scoreboard queues
    typedef struct {int kind; int cyc;} evt_t;      // kind 0 = done, 1 = error
    typedef struct {int cyc; logic [23:0] val;} px_t;
    logic [8:0] addr_q[$];
    evt_t       evt_q[$];
    px_t        px_q[$];

    // ROM model state
    int         rom_stage = 0;
    logic [8:0] rom_addr = '0;
    logic       rom_read_prev = 1'b0;
    logic       withhold_en = 1'b0;
    logic [8:0] withhold_addr = '0;
    logic       inject = 1'b0;

    // Monitor scratch
    logic       mon_prev_read = 1'b0;
    evt_t       mon_evt;
    px_t        mon_px;
    logic [8:0] mon_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // ROM model: edge-detects o_read, returns A00000|addr two cycles after REQ.
    always @(negedge clk) begin
        if (!rst_n) begin
            rom_stage     = 0;
            valid         = 1'b0;
            rom_read_prev = 1'b0;
        end else begin
            valid = 1'b0;
            if (rom_stage == 2) begin
                if (!(withhold_en && rom_addr == withhold_addr)) begin
                    valid    = 1'b1;
                    rgb_data = 24'hA00000 | {15'd0, rom_addr};
                end
                rom_stage = 0;
            end else if (rom_stage == 1) begin
                rom_stage = 2;
            end
            if (inject) begin
                valid    = 1'b1;
                rgb_data = 24'h0BAD00;
                inject   = 1'b0;
            end
            if (read && !rom_read_prev) begin
                rom_stage = 1;
                rom_addr  = address;
            end
            rom_read_prev = read;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin : monitor
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (read && !mon_prev_read) begin
                if (addr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: got address %0h expected no strobe (cycle %0d)", address, cyc);
                end else begin
                    mon_addr = addr_q.pop_front();
                    check("read_addr", 32'(address), 32'(mon_addr));
                end
            end
            mon_prev_read = read;
            if (done) begin
                if (evt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
                end else begin
                    mon_evt = evt_q.pop_front();
                    check("done_cycle", 32'(cyc), (mon_evt.kind == 0) ? 32'(mon_evt.cyc) : 32'hFFFFFFFF);
                end
            end
            if (error) begin
                if (evt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_error: got error expected none (cycle %0d)", cyc);
                end else begin
                    mon_evt = evt_q.pop_front();
                    check("error_cycle", 32'(cyc), (mon_evt.kind == 1) ? 32'(mon_evt.cyc) : 32'hFFFFFFFF);
                end
            end
            while (px_q.size() > 0 && px_q[0].cyc <= cyc) begin
                mon_px = px_q.pop_front();
                check("px_rgb", 32'(px_rgb), 32'(mon_px.val));
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulses i_start for one cycle; t0 is the cycle in which start is high.
    task automatic issue(input int r, output int t0);
        @(negedge clk);
        row   = 5'(r);
        start = 1'b1;
        t0    = cyc;
    endtask

    task automatic end_pulse();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_addrs(input int r, input int npix);
        for (int i = 0; i < npix; i++) addr_q.push_back(9'(r * 16 + i));
    endtask

    task automatic push_evt(input int kind, input int c);
        evt_t e;
        e.kind = kind;
        e.cyc  = c;
        evt_q.push_back(e);
    endtask

    task automatic read_px(input int idx, input logic [23:0] exp);
        px_t p;
        @(negedge clk);
        px_index = 4'(idx);
        p.cyc = cyc + 1;
        p.val = exp;
        px_q.push_back(p);
    endtask

    initial begin : stimulus
        int t0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_read", 32'(read), 0);
        check("rst_address", 32'(address), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_line_valid", 32'(line_valid), 0);
        check("rst_px_rgb", 32'(px_rgb), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_done_error", {30'd0, done, error}, 0);

        // Row 3: addresses 48..63, done in cycle 49
        issue(3, t0);
        push_addrs(3, 16);
        push_evt(0, t0 + 49);
        end_pulse();
        wait_until(t0 + 10);
        check("row3_busy_mid", 32'(busy), 1);
        check("row3_line_valid_mid", 32'(line_valid), 0);
        wait_until(t0 + 51);
        check("row3_line_valid", 32'(line_valid), 1);
        check("row3_busy_end", 32'(busy), 0);
        read_px(5, 24'hA00035);
        read_px(0, 24'hA00030);
        read_px(15, 24'hA0003F);
        repeat (2) @(negedge clk);

        // Row 17: last address 287
        issue(17, t0);
        push_addrs(17, 16);
        push_evt(0, t0 + 49);
        end_pulse();
        wait_until(t0 + 51);
        read_px(15, 24'hA0011F);
        read_px(0, 24'hA00110);
        repeat (2) @(negedge clk);

        // Row 18: out of range
        issue(18, t0);
        push_evt(1, t0 + 1);
        end_pulse();
        check("bad_row_busy", 32'(busy), 0);
        wait_until(t0 + 5);
        check("bad_row_line_valid_kept", 32'(line_valid), 1);
        check("bad_row_busy_after", 32'(busy), 0);

        // Row 2 with pixel 4 withheld: timeout
        withhold_en   = 1'b1;
        withhold_addr = 9'd36;
        issue(2, t0);
        push_addrs(2, 5);
        push_evt(1, t0 + 29);
        end_pulse();
        wait_until(t0 + 20);
        check("timeout_busy_mid", 32'(busy), 1);
        wait_until(t0 + 31);
        check("timeout_busy", 32'(busy), 0);
        check("timeout_line_valid", 32'(line_valid), 0);
        wait_until(t0 + 50);
        withhold_en = 1'b0;

        // Row 7 with ignored mid-fetch start and spurious idle valid
        issue(7, t0);
        push_addrs(7, 16);
        push_evt(0, t0 + 49);
        end_pulse();
        wait_until(t0 + 10);
        row   = 5'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 51);
        inject = 1'b1;
        repeat (3) @(negedge clk);
        check("row7_line_valid", 32'(line_valid), 1);
        read_px(15, 24'hA0007F);
        read_px(4, 24'hA00074);
        read_px(0, 24'hA00070);
        repeat (2) @(negedge clk);

        // Row 5 interrupted by reset at pixel 7
        issue(5, t0);
        push_addrs(5, 8);
        end_pulse();
        wait_until(t0 + 22);
        check("pre_reset_read", 32'(read), 1);
        check("pre_reset_address", 32'(address), 87);
        rst_n = 1'b0;
        #1;
        check("mid_reset_read", 32'(read), 0);
        check("mid_reset_address", 32'(address), 0);
        check("mid_reset_px_rgb", 32'(px_rgb), 0);
        check("mid_reset_busy", 32'(busy), 0);
        check("mid_reset_line_valid", 32'(line_valid), 0);
        check("mid_reset_done_error", {30'd0, done, error}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Row 0 after reset
        issue(0, t0);
        push_addrs(0, 16);
        push_evt(0, t0 + 49);
        end_pulse();
        wait_until(t0 + 51);
        check("row0_line_valid", 32'(line_valid), 1);
        read_px(3, 24'hA00003);
        read_px(15, 24'hA0000F);
        repeat (4) @(negedge clk);

        check("addr_q_drained", 32'(addr_q.size()), 0);
        check("evt_q_drained", 32'(evt_q.size()), 0);
        check("px_q_drained", 32'(px_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
